// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Opcodes, status-bit indices and instruction field positions
//               shared by the 4-bit CPU datapath and its control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [3:0] OP_MOV  = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_NOT  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Status register layout {Z,C,N,V}
    localparam int STAT_Z = 3;
    localparam int STAT_C = 2;
    localparam int STAT_N = 1;
    localparam int STAT_V = 0;

    localparam int IR_OP_LSB  = 8;
    localparam int IR_OP_W    = 4;
    localparam int IR_RD_LSB  = 6;
    localparam int IR_RS_LSB  = 4;
    localparam int IR_REG_W   = 2;
    localparam int IR_IMM_LSB = 0;
    localparam int IR_IMM_W   = 4;

endpackage
`default_nettype wire

// File: rtl/cpu_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath_if
// Description : Control-strobe, status and instruction-memory bus between the
//               control FSM (master) and the datapath (slave).
//               Debug read port present only with CPU_DATAPATH_DEBUG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_datapath_if #(
    parameter int DATA_W  = 4,
    parameter int PC_W    = 4,
    parameter int INSTR_W = 12
);
    logic               ir_load_en;
    logic               reg_write_en;
    logic               alu_en;
    logic               jump_en;
    logic               halt;
    logic [3:0]         alu_opcode;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [3:0]         opcode;
    logic [3:0]         status_reg;
    logic [DATA_W-1:0]  alu_result;
    logic               halted;
`ifdef CPU_DATAPATH_DEBUG_EN
    logic [1:0]         dbg_sel;
    logic [DATA_W-1:0]  dbg_data;
`endif

    modport master (
        output ir_load_en, reg_write_en, alu_en, jump_en, halt, alu_opcode,
        output imem_data,
        input  imem_addr, opcode, status_reg, alu_result, halted
`ifdef CPU_DATAPATH_DEBUG_EN
        , output dbg_sel
        , input  dbg_data
`endif
    );

    modport slave (
        input  ir_load_en, reg_write_en, alu_en, jump_en, halt, alu_opcode,
        input  imem_data,
        output imem_addr, opcode, status_reg, alu_result, halted
`ifdef CPU_DATAPATH_DEBUG_EN
        , input  dbg_sel
        , output dbg_data
`endif
    );

endinterface
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_alu
// Description : Combinational ALU; returns result and {Z,C,N,V} flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  wire logic [3:0]        op_i,
    input  wire logic [DATA_W-1:0] a_i,
    input  wire logic [DATA_W-1:0] b_i,
    output logic      [DATA_W-1:0] result_o,
    output logic      [3:0]        flags_o
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op_i)
            OP_ADD: begin
                {w_c, w_res} = {1'b0, a_i} + {1'b0, b_i};
                w_v = (a_i[MSB] == b_i[MSB]) && (w_res[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                w_res = a_i - b_i;
                // Carry is "no borrow", i.e. A >= B unsigned
                w_c   = (a_i >= b_i);
                w_v   = (a_i[MSB] != b_i[MSB]) && (w_res[MSB] != a_i[MSB]);
            end
            OP_AND: w_res = a_i & b_i;
            OP_OR:  w_res = a_i | b_i;
            OP_XOR: w_res = a_i ^ b_i;
            OP_NOT: w_res = ~b_i;
            OP_SHL: begin
                w_res = {a_i[MSB-1:0], 1'b0};
                w_c   = a_i[MSB];
            end
            OP_MOV, OP_HALT: w_res = '0;
            default:         w_res = '0;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[STAT_Z] = (w_res == '0);
        flags_o[STAT_C] = w_c;
        flags_o[STAT_N] = w_res[MSB];
        flags_o[STAT_V] = w_v;
    end

    assign result_o = w_res;

endmodule
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath
// Description : Strobe-driven 4-bit CPU datapath: PC, IR, register file, ALU
//               result latch, status register and sticky halted bit.
//               Optional macro CPU_DATAPATH_DEBUG_EN adds a register read port.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int PC_W     = 4,
    parameter int NUM_REGS = 4,
    parameter int INSTR_W  = 12
) (
    input  wire logic     clk,
    input  wire logic     reset,
    cpu_datapath_if.slave bus
);
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  alu_result_q, alu_result_d;
    logic [3:0]         status_q, status_d;
    logic               halted_q, halted_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               rf_we_d;
    logic [DATA_W-1:0]  rf_wdata_d;

    logic                w_frozen;
    logic [IR_OP_W-1:0]  w_opcode;
    logic [IR_REG_W-1:0] w_rd;
    logic [IR_REG_W-1:0] w_rs;
    logic [IR_IMM_W-1:0] w_imm;
    logic [DATA_W-1:0]   w_alu_res;
    logic [3:0]          w_alu_flags;

    assign w_frozen = bus.halt | halted_q;
    assign w_opcode = ir_q[IR_OP_LSB  +: IR_OP_W];
    assign w_rd     = ir_q[IR_RD_LSB  +: IR_REG_W];
    assign w_rs     = ir_q[IR_RS_LSB  +: IR_REG_W];
    assign w_imm    = ir_q[IR_IMM_LSB +: IR_IMM_W];

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (bus.alu_opcode),
        .a_i      (regs_q[w_rd]),
        .b_i      (regs_q[w_rs]),
        .result_o (w_alu_res),
        .flags_o  (w_alu_flags)
    );

    always_comb begin
        pc_d         = pc_q;
        ir_d         = ir_q;
        alu_result_d = alu_result_q;
        status_d     = status_q;
        halted_d     = halted_q | bus.halt;
        rf_we_d      = 1'b0;
        rf_wdata_d   = alu_result_q;
        if (!w_frozen) begin
            if (bus.ir_load_en) begin
                ir_d = bus.imem_data;
                pc_d = pc_q + PC_W'(1);
            end
            // Jump target is the imm of the IR held before this edge
            if (bus.jump_en) begin
                pc_d = PC_W'(w_imm);
            end
            if (bus.alu_en) begin
                alu_result_d = w_alu_res;
                status_d     = w_alu_flags;
            end
            if (bus.reg_write_en) begin
                rf_we_d    = 1'b1;
                rf_wdata_d = (w_opcode == OP_MOV) ? DATA_W'(w_imm) : alu_result_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= '0;
            ir_q         <= '0;
            alu_result_q <= '0;
            status_q     <= '0;
            halted_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            alu_result_q <= alu_result_d;
            status_q     <= status_d;
            halted_q     <= halted_d;
            if (rf_we_d) begin
                regs_q[w_rd] <= rf_wdata_d;
            end
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.opcode     = w_opcode;
    assign bus.status_reg = status_q;
    assign bus.alu_result = alu_result_q;
    assign bus.halted     = halted_q;

`ifdef CPU_DATAPATH_DEBUG_EN
    assign bus.dbg_data = regs_q[bus.dbg_sel];
`endif

endmodule
`default_nettype wire

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Executing end of the 4-bit CPU control interface.
- Consumes the control strobes (ir_load_en, reg_write_en, alu_en, jump_en, halt, alu_opcode) and owns PC, IR, register file, ALU result latch and status register.
- Returns opcode and status_reg to the control FSM.
- Sits between the control FSM and an external combinational-read instruction memory.

Parameters:
- DATA_W, 4, register/ALU data width.
- PC_W, 4, program counter width (16-entry program space).
- NUM_REGS, 4, register file depth; register index field is 2 bits.
- INSTR_W, 12, instruction width: opcode[11:8], rd[7:6], rs[5:4], imm[3:0].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ir_load_en  input  1  load IR from imem_data; PC increments.
- reg_write_en  input  1  write register file at rd.
- alu_en  input  1  compute ALU op; latch result and flags.
- jump_en  input  1  load PC from IR imm field.
- halt  input  1  freeze all state.
- alu_opcode  input  4  ALU operation select.
- imem_addr  output  PC_W  instruction memory address (equals PC).
- imem_data  input  INSTR_W  instruction word, combinational from imem_addr.
- opcode  output  4  IR[11:8].
- status_reg  output  4  {Z,C,N,V}; Z at bit 3.
- alu_result  output  DATA_W  latched ALU result.
- halted  output  1  registered; high from cycle after first halt.

Behaviour:
- Reset (synchronous, active-high), applied on the clk edge where reset=1:
  - PC, IR, all registers, alu_result, status_reg = 0; halted = 0.
  - Hence opcode=0 and imem_addr=0 in the cycle after reset.
  - Reset mid-operation discards all state, including halted.
- halt:
  - If halt=1 (or halted=1), every state update is suppressed; halted<=1.
  - halted is sticky until reset.
  - halt takes priority over all strobes in the same cycle.
- ir_load_en:
  - IR <= imem_data.
  - PC <= PC+1 mod 2^PC_W; wraps 15 -> 0.
- jump_en:
  - PC <= IR[3:0] zero-extended to PC_W.
  - If asserted with ir_load_en, jump wins for PC; IR still loads imem_data.
  - Jump target comes from the old IR.
- alu_en: operands A = R[rd], B = R[rs]; result latched into alu_result next edge.
  - 1000 ADD: A+B; C = carry out; V = signed overflow.
  - 1001 SUB: A-B; C = no-borrow (A>=B unsigned); V = signed overflow.
  - 1010 AND, 1011 OR, 1100 XOR: bitwise; C=0, V=0.
  - 1101 NOT: ~B; C=0, V=0.
  - 1110 SHL: A<<1; C = A[3]; V=0.
  - Any other alu_opcode: result 0; C=0, V=0.
  - For all ops: Z = (result==0), N = result[3].
  - status_reg updates only on alu_en; holds otherwise.
- reg_write_en:
  - If opcode==0101 (MOV): R[rd] <= imm; else R[rd] <= alu_result.
  - MOV never changes status_reg.
  - Writing R[rd] with alu_en in the same cycle: write uses the pre-edge alu_result; ALU reads pre-edge register values.
- Latency:
  - IR/opcode valid 1 cycle after ir_load_en.
  - alu_result/status_reg valid 1 cycle after alu_en.
  - Register write visible 1 cycle after reg_write_en.
- No internal FSM; sequencing is owned by the control FSM. The datapath is a strobe-responder with one sticky halted state bit.

Optional Feature:
- Macro: CPU_DATAPATH_DEBUG_EN.
- Defined:
  - Adds input dbg_sel[1:0] and output dbg_data[DATA_W-1:0] = R[dbg_sel], combinational, no side effects.
  - dbg_data reads the pre-edge value during a same-cycle write.
- Undefined: ports absent; no debug logic.

Decomposition:
- Package cpu_pkg:
  - Opcode constants: OP_ADD..OP_SHL, OP_MOV=0101, OP_HALT=1111.
  - Status bit indices: Z=3, C=2, N=1, V=0.
  - Instruction field positions.
  - Shared by this block and the control FSM.
- One sub-module, cpu_alu: combinational; inputs op, A, B; outputs result and flags.
- Register file, PC and IR stay inline.

Test Plan:
- Reset: hold reset 2 cycles with strobes toggling -> PC=0, IR=0, status_reg=0000, halted=0, imem_addr=0.
- MOV then ADD: imem[0]=0101_00_00_0111, imem[1]=0101_01_00_1001, imem[2]=1000_00_01_0000, sequenced FETCH/DECODE/EXECUTE/WRITE_BACK.
  - Expect R0=7, R1=9.
  - After ADD, alu_result=0000, status_reg=1100 (Z=1, C=1, N=0, V=0), R0=0.
- SUB 5-5: -> result 0, status_reg=1100 (Z=1, C=1).
- SUB 3-5: -> result 1110, status_reg=0010 (N=1, C=0).
- PC wrap: 16 fetches from PC=0 -> imem_addr returns to 0.
- Jump: jump_en with IR imm=1010 -> PC=10.
- Jump + fetch same cycle: jump_en with ir_load_en -> PC=10 (jump wins); IR=imem_data.
- Halt: halt=1 with reg_write_en=1 and ir_load_en=1 in the same cycle -> no register, PC or IR change; halted=1 next cycle and stays 1 with halt deasserted; reset clears it.
